cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Front-end controller for the fully associative write-back cache. Two requesters (port 0 and port 1) share one cache through round-robin arbitration.
- Sequences each access as a single-cycle cache strobe followed by result capture.
- On a dirty eviction, performs the write-back to main memory over a req/ack handshake before responding to the requester.
- Keeps saturating hit/miss/write-back statistics and a sticky write-back timeout error.

Parameters:
- ADDR_WIDTH, 8, address width; matches the cache.
- DATA_WIDTH, 32, data word width; matches the cache.
- WB_TIMEOUT, 64, maximum cycles to wait for mem_wb_ack (must be ≥2).
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
req0_valid  in  1  port 0 request valid.
req0_write  in  1  port 0 request type: 1 = write, 0 = read.
req0_addr  in  ADDR_WIDTH  port 0 address.
req0_wdata  in  DATA_WIDTH  port 0 write data.
req0_ready  out  1  port 0 request accepted this cycle.
req0_rvalid  out  1  port 0 response pulse.
req0_rdata  out  DATA_WIDTH  port 0 read data.
req0_hit  out  1  port 0 hit flag; valid with req0_rvalid.
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata, req1_hit: same as port 0, for port 1.
c_read  out  1  cache read strobe.
c_write  out  1  cache write strobe.
c_addr  out  ADDR_WIDTH  cache address.
c_wdata  out  DATA_WIDTH  cache write data.
c_rdata  in  DATA_WIDTH  cache read data.
c_hit  in  1  cache hit.
c_dirty_evict  in  1  cache dirty eviction.
c_evict_addr  in  ADDR_WIDTH  evicted line address.
c_evict_data  in  DATA_WIDTH  evicted line data.
mem_wb_req  out  1  write-back request to memory.
mem_wb_addr  out  ADDR_WIDTH  write-back address.
mem_wb_data  out  DATA_WIDTH  write-back data.
mem_wb_ack  in  1  memory write-back acknowledge.
busy  out  1  controller not in IDLE.
wb_err  out  1  sticky: a write-back timed out.
hit_cnt, miss_cnt, wb_cnt  out  CNT_WIDTH each  saturating statistics counters.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - FSM goes to IDLE; all outputs are 0.
  - Counters and wb_err clear.
  - Round-robin pointer last_grant=1, so port 0 has first priority.
  - Reset mid-write-back drops mem_wb_req immediately; the pending response is discarded.
- **FSM states:** IDLE, ISSUE, CAPTURE, WB, RESP.
- **IDLE:**
  - reqN_ready is combinational: the port is granted when its valid is high and, if both are valid, it is not last_grant.
  - On valid&ready, latch port ID, write, addr and wdata; set last_grant to the granted port; go to ISSUE.
  - At most one ready is high per cycle.
- **ISSUE (exactly 1 cycle):**
  - Drive c_read or c_write high with the latched addr/wdata; go to CAPTURE.
- **CAPTURE:**
  - Register c_hit, c_rdata, c_dirty_evict, c_evict_addr and c_evict_data.
  - Increment hit_cnt or miss_cnt.
  - If c_dirty_evict=1, go to WB; otherwise go to RESP.
- **WB:**
  - mem_wb_req is held high with a stable mem_wb_addr/mem_wb_data.
  - On mem_wb_ack=1: wb_cnt++, deassert mem_wb_req next cycle, go to RESP.
  - Timeout counter starts at 0 on WB entry. If it reaches WB_TIMEOUT-1 without an ack: set wb_err, abandon, go to RESP (wb_cnt is not incremented).
  - mem_wb_ack outside WB is ignored.
- **RESP (1 cycle):**
  - Pulse the granted port's rvalid and drive its hit.
  - rdata = captured c_rdata for reads; 0 for writes.
  - Go to IDLE; a new grant is possible in the next cycle.
- **Latency:** with the handshake in cycle T, rvalid occurs in cycle T+3 without write-back. With write-back, rvalid occurs 1 cycle after the ack cycle.
- **Throughput:** one request per 4 cycles minimum.
- **Requester rule:** requesters hold valid and payload until ready. Requests arriving while busy wait; there is no queueing.
- **Counters:** saturate at all-ones and never wrap. Simultaneous increments cannot occur.
- Outputs not being driven in a given state are held at 0: c_* strobes, mem_wb_req, and the non-granted port's rvalid/hit/rdata.

Test Plan:
1. Reset, then port 0 writes addr 0x20, data 0xA5A5A5A5, cache model misses:
   - c_write pulses 1 cycle at T+1.
   - req0_rvalid at T+3 with hit=0, rdata=0.
   - miss_cnt=1.
2. Port 0 reads 0x20, cache returns hit with 0xA5A5A5A5:
   - req0_rvalid at T+3 with hit=1, rdata=0xA5A5A5A5.
   - hit_cnt=1.
3. Both ports valid every cycle for 4 requests (port 0 to 0x30, port 1 to 0x40):
   - Grants alternate 0,1,0,1.
   - No cycle has both readys high.
4. Dirty eviction with evict_addr 0x30, evict_data 0xC0, ack 5 cycles after WB entry:
   - mem_wb_req is high for exactly 6 cycles with addr 0x30, data 0xC0.
   - rvalid 1 cycle after ack; wb_cnt=1.
5. Dirty eviction with no ack:
   - mem_wb_req is high for 64 cycles, then wb_err=1 (sticky).
   - Response is still delivered; wb_cnt unchanged.
6. rst asserted in the 3rd WB cycle:
   - mem_wb_req drops asynchronously; no rvalid is issued.
   - Counters=0; the next request is served normally.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Round-robin front end for the write-back cache: two requesters,
// one cache strobe per access, dirty-line write-back over req/ack.
module cache_req_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WB_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_hit,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_hit,
  output logic                  c_read,
  output logic                  c_write,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_wdata,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  c_hit,
  input  logic                  c_dirty_evict,
  input  logic [ADDR_WIDTH-1:0] c_evict_addr,
  input  logic [DATA_WIDTH-1:0] c_evict_data,
  output logic                  mem_wb_req,
  output logic [ADDR_WIDTH-1:0] mem_wb_addr,
  output logic [DATA_WIDTH-1:0] mem_wb_data,
  input  logic                  mem_wb_ack,
  output logic                  busy,
  output logic                  wb_err,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  wb_cnt
);

  localparam int TW = (WB_TIMEOUT > 2) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(WB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, WB, RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  lg_q, lg_d;
  logic                  port_q, port_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] ev_addr_q, ev_addr_d;
  logic [DATA_WIDTH-1:0] ev_data_q, ev_data_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]  wb_cnt_q, wb_cnt_d;
  logic                  wb_err_q, wb_err_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lg_q       <= 1'b1;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      ev_addr_q  <= '0;
      ev_data_q  <= '0;
      tmo_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lg_q       <= lg_d;
      port_q     <= port_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hit_q      <= hit_d;
      rdata_q    <= rdata_d;
      ev_addr_q  <= ev_addr_d;
      ev_data_q  <= ev_data_d;
      tmo_q      <= tmo_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lg_d        = lg_q;
    port_d      = port_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    rdata_d     = rdata_q;
    ev_addr_d   = ev_addr_q;
    ev_data_d   = ev_data_q;
    tmo_d       = tmo_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    wb_err_d    = wb_err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    req0_rvalid = 1'b0;
    req1_rvalid = 1'b0;
    req0_hit    = 1'b0;
    req1_hit    = 1'b0;
    req0_rdata  = '0;
    req1_rdata  = '0;
    c_read      = 1'b0;
    c_write     = 1'b0;
    c_addr      = '0;
    c_wdata     = '0;
    mem_wb_req  = 1'b0;
    mem_wb_addr = '0;
    mem_wb_data = '0;

    unique case (state_q)
      IDLE: begin
        // a port loses a tie only if it won the previous grant
        req0_ready = req0_valid && (!req1_valid || lg_q);
        req1_ready = req1_valid && (!req0_valid || !lg_q);
        if (req0_ready) begin
          port_d  = 1'b0;
          lg_d    = 1'b0;
          wr_d    = req0_write;
          addr_d  = req0_addr;
          wdata_d = req0_wdata;
          state_d = ISSUE;
        end else if (req1_ready) begin
          port_d  = 1'b1;
          lg_d    = 1'b1;
          wr_d    = req1_write;
          addr_d  = req1_addr;
          wdata_d = req1_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        c_read  = !wr_q;
        c_write = wr_q;
        c_addr  = addr_q;
        c_wdata = wr_q ? wdata_q : '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        hit_d     = c_hit;
        rdata_d   = c_rdata;
        ev_addr_d = c_evict_addr;
        ev_data_d = c_evict_data;
        tmo_d     = '0;
        if (c_hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else       miss_cnt_d = sat_inc(miss_cnt_q);
        state_d = c_dirty_evict ? WB : RESP;
      end
      WB: begin
        mem_wb_req  = 1'b1;
        mem_wb_addr = ev_addr_q;
        mem_wb_data = ev_data_q;
        if (mem_wb_ack) begin
          wb_cnt_d = sat_inc(wb_cnt_q);
          state_d  = RESP;
        end else if (tmo_q == TMO_LAST) begin
          wb_err_d = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (port_q) begin
          req1_rvalid = 1'b1;
          req1_hit    = hit_q;
          req1_rdata  = wr_q ? '0 : rdata_q;
        end else begin
          req0_rvalid = 1'b1;
          req0_hit    = hit_q;
          req0_rdata  = wr_q ? '0 : rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign wb_err   = wb_err_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: vector table plus
// hand-written arbitration, write-back, timeout and reset sequences.
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready, req0_rvalid, req0_hit;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_rvalid, req1_hit;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic        c_read, c_write, c_hit, c_dirty_evict;
  logic [7:0]  c_addr, c_evict_addr;
  logic [31:0] c_wdata, c_rdata, c_evict_data;
  logic        mem_wb_req, mem_wb_ack, busy, wb_err;
  logic [7:0]  mem_wb_addr;
  logic [31:0] mem_wb_data;
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;

  always #5 clk = ~clk;

  cache_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_hit(req0_hit),
    .req1_valid(req1_valid), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_hit(req1_hit),
    .c_read(c_read), .c_write(c_write),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_hit(c_hit),
    .c_dirty_evict(c_dirty_evict),
    .c_evict_addr(c_evict_addr), .c_evict_data(c_evict_data),
    .mem_wb_req(mem_wb_req), .mem_wb_addr(mem_wb_addr),
    .mem_wb_data(mem_wb_data), .mem_wb_ack(mem_wb_ack),
    .busy(busy), .wb_err(wb_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  typedef struct {
    bit          v0;
    bit          v1;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          chit;
    logic [31:0] crd;
    bit          eport;
    bit          ehit;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[5];
  int   nvec = 0;
  int   nerr = 0;
  int   exp_hit = 0;
  int   exp_miss = 0;
  int   exp_wb = 0;
  int   exp_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_hit_cnt"}, 32'(hit_cnt), exp_hit);
    chk({nm, "_miss_cnt"}, 32'(miss_cnt), exp_miss);
    chk({nm, "_wb_cnt"}, 32'(wb_cnt), exp_wb);
    chk({nm, "_wb_err"}, 32'(wb_err), exp_err);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req0_valid = v.v0;    req1_valid = v.v1;
    req0_write = v.wr;    req1_write = v.wr;
    req0_addr  = v.addr;  req1_addr  = v.addr;
    req0_wdata = v.wdata; req1_wdata = v.wdata;
    c_hit = v.chit;       c_rdata = v.crd;
    #1;
    chk("ready0", 32'(req0_ready), 32'(v.eport == 1'b0));
    chk("ready1", 32'(req1_ready), 32'(v.eport == 1'b1));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("c_read", 32'(c_read), 32'(!v.wr));
    chk("c_write", 32'(c_write), 32'(v.wr));
    chk("c_addr", 32'(c_addr), 32'(v.addr));
    chk("c_wdata", c_wdata, v.wr ? v.wdata : 32'h0);
    @(negedge clk);
    chk("early_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'h0);
    @(negedge clk);
    chk("rvalid0", 32'(req0_rvalid), 32'(v.eport == 1'b0));
    chk("rvalid1", 32'(req1_rvalid), 32'(v.eport == 1'b1));
    chk("resp_hit", 32'(v.eport ? req1_hit : req0_hit), 32'(v.ehit));
    chk("resp_rdata", v.eport ? req1_rdata : req0_rdata, v.erd);
    if (v.chit) exp_hit++;
    else exp_miss++;
    chk_cnts("vec");
  endtask

  task automatic start_dirty_read();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_write = 1'b0; req0_addr = 8'h50;
    c_hit = 1'b0; c_rdata = 32'h0000_5555;
    c_dirty_evict = 1'b1;
    c_evict_addr = 8'h30; c_evict_data = 32'hC0;
    #1;
    chk("wb_ready0", 32'(req0_ready), 32'h1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_seq(input bit ack, input int exp_n);
    int n = 0;
    bit bad = 1'b0;
    start_dirty_read();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mem_wb_req) break;
      n++;
      if (mem_wb_addr !== 8'h30 || mem_wb_data !== 32'hC0) bad = 1'b1;
      if (ack && n == 6) mem_wb_ack = 1'b1;
    end
    mem_wb_ack = 1'b0;
    c_dirty_evict = 1'b0;
    exp_miss++;
    if (ack) exp_wb++;
    else exp_err = 1;
    chk("wb_req_len", n, exp_n);
    chk("wb_stable", 32'(bad), 32'h0);
    chk("wb_rvalid", 32'(req0_rvalid), 32'h1);
    chk("wb_rdata", req0_rdata, 32'h0000_5555);
    chk_cnts("wb");
  endtask

  initial begin
    tbl[0] = '{1, 0, 1, 8'h20, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF,
               0, 0, 32'h0};
    tbl[1] = '{1, 0, 0, 8'h20, 32'h0, 1, 32'hA5A5_A5A5,
               0, 1, 32'hA5A5_A5A5};
    tbl[2] = '{1, 1, 0, 8'h40, 32'h0, 0, 32'h1234_5678,
               1, 0, 32'h1234_5678};
    tbl[3] = '{0, 1, 1, 8'h41, 32'h0F0F_0F0F, 1, 32'hDEAD_BEEF,
               1, 1, 32'h0};
    tbl[4] = '{1, 1, 0, 8'h60, 32'h0, 1, 32'h0000_0077,
               0, 1, 32'h0000_0077};

    rst = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    c_rdata = 0; c_hit = 0; c_dirty_evict = 0;
    c_evict_addr = 0; c_evict_data = 0; mem_wb_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobes", 32'({c_read, c_write, mem_wb_req}), 32'h0);
    chk("rst_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'h0);
    chk_cnts("rst");
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // both ports requesting every cycle
    begin
      int g = 0;
      int grants[4] = '{-1, -1, -1, -1};
      bit both = 1'b0;
      @(negedge clk);
      c_hit = 1'b0; c_dirty_evict = 1'b0;
      req0_valid = 1; req0_write = 0; req0_addr = 8'h30;
      req1_valid = 1; req1_write = 0; req1_addr = 8'h40;
      for (int i = 0; i < 60 && g < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        if (req0_ready && req1_ready) both = 1'b1;
        if (req0_ready) grants[g++] = 0;
        else if (req1_ready) grants[g++] = 1;
      end
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      exp_miss += 4;
      chk("arb_count", g, 4);
      chk("arb_one_ready", 32'(both), 32'h0);
      for (int i = 0; i < 4; i++) chk("arb_grant", grants[i], i % 2);
      chk("arb_idle", 32'(busy), 32'h0);
      chk_cnts("arb");
    end

    wb_seq(1'b1, 6);
    wb_seq(1'b0, 64);
    repeat (3) @(negedge clk);
    chk("wb_err_sticky", 32'(wb_err), 32'h1);

    begin
      int rv = 0;
      start_dirty_read();
      repeat (3) @(negedge clk);
      chk("rst_wb_req_before", 32'(mem_wb_req), 32'h1);
      rst = 1'b0;
      #1;
      chk("rst_wb_req_async", 32'(mem_wb_req), 32'h0);
      chk("rst_wb_busy", 32'(busy), 32'h0);
      c_dirty_evict = 1'b0;
      exp_hit = 0; exp_miss = 0; exp_wb = 0; exp_err = 0;
      chk_cnts("rst_mid");
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i == 2) rst = 1'b1;
        if (req0_rvalid || req1_rvalid) rv++;
      end
      chk("rst_no_rvalid", rv, 0);
    end

    run_vec(tbl[4]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
